rr_lock_arb: RTL and testbench



---
 rtl/rr_lock_arb_pkg.sv | 7 +
 rtl/rr_prio_enc.sv | 26 ++
 rtl/rr_lock_arb.sv | 71 +++++++
 tb/tb_rr_lock_arb.sv | 120 ++++++++++++
 4 files changed

// File: rtl/rr_lock_arb_pkg.sv
// rr_lock_arb_pkg: shared port count, grant-index width and arbiter state encodings
package rr_lock_arb_pkg;
   localparam int RR_PORT = 5;
   localparam int RR_NPORT = RR_PORT + 1;
   localparam int RR_IDW = $clog2(RR_NPORT);
   typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_e;
endpackage

// File: rtl/rr_prio_enc.sv
// rr_prio_enc: rotating priority encoder, first set bit of req scanning from ptr upward with wrap
module rr_prio_enc import rr_lock_arb_pkg::*; #(
   parameter int NPORT = RR_NPORT,
   parameter int IDW = RR_IDW
) (
   input  logic [NPORT-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic [NPORT-1:0] gnt,
   output logic [IDW-1:0]   idx
);
   always_comb begin
      gnt = '0;
      idx = '0;
      // Scan farthest-first so the hit nearest to ptr is written last and wins
      for (int k = NPORT - 1; k >= 0; k--) begin
         int j;
         j = int'(ptr) + k;
         j = (j >= NPORT) ? j - NPORT : j;
         if (req[j]) begin
            gnt = '0;
            gnt[j] = 1'b1;
            idx = IDW'(j);
         end
      end
   end
endmodule

// File: rtl/rr_lock_arb.sv
// rr_lock_arb: round-robin output-port arbiter that locks the grant until the owner's last flit.
// Optional hold timeout forcing release is enabled by RR_LOCK_ARB_HOLD_TIMEOUT_EN.
module rr_lock_arb import rr_lock_arb_pkg::*; #(
   parameter int NPORT = RR_NPORT,
   parameter int IDW = RR_IDW,
   parameter int MAX_HOLD = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NPORT-1:0] req,
   input  logic [NPORT-1:0] eop,
   input  logic             fire,
   output logic [NPORT-1:0] grt,
   output logic             grt_vld,
   output logic [IDW-1:0]   grt_id,
   output logic             timeout
);
   state_e           state_q;
   logic [NPORT-1:0] grt_q, win;
   logic [IDW-1:0]   id_q, ptr_q, nxt_ptr, arb_ptr, win_id;
   logic             vld_q, to_q, rel_eop, expire, rel, grant_new;

   assign nxt_ptr = (id_q == IDW'(NPORT - 1)) ? '0 : id_q + 1'b1;
   assign rel_eop = (state_q == ST_LOCK) && fire && eop[id_q];
   assign rel = rel_eop || expire;
   // On a release cycle the next owner is chosen from the advanced pointer for zero bubble
   assign arb_ptr = (state_q == ST_LOCK) ? nxt_ptr : ptr_q;
   assign grant_new = ((state_q == ST_IDLE) || rel) && (|req);

   rr_prio_enc #(.NPORT(NPORT), .IDW(IDW)) u_enc (
      .req(req),
      .ptr(arb_ptr),
      .gnt(win),
      .idx(win_id)
   );

`ifdef RR_LOCK_ARB_HOLD_TIMEOUT_EN
   localparam int CW = $clog2(MAX_HOLD) + 1;
   logic [CW-1:0] hold_q;
   assign expire = (state_q == ST_LOCK) && !fire && (hold_q == CW'(MAX_HOLD - 1));
   always_ff @(posedge clk or posedge rst)
      if (rst) hold_q <= '0;
      else hold_q <= (grant_new || fire) ? '0 : (state_q == ST_LOCK) ? hold_q + 1'b1 : hold_q;
`else
   assign expire = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= ST_IDLE;
         grt_q <= '0;
         id_q <= '0;
         vld_q <= 1'b0;
         ptr_q <= '0;
         to_q <= 1'b0;
      end else begin
         to_q <= expire;
         if ((state_q == ST_IDLE) || rel) begin
            if (rel) ptr_q <= nxt_ptr;
            state_q <= (|req) ? ST_LOCK : ST_IDLE;
            grt_q <= win;
            id_q <= win_id;
            vld_q <= |req;
         end
      end

   assign grt = grt_q;
   assign grt_vld = vld_q;
   assign grt_id = id_q;
   assign timeout = to_q;
endmodule

// File: tb/tb_rr_lock_arb.sv
// tb_rr_lock_arb: table-driven check of rr_lock_arb plus hand sequences for reset and hold timeout
module tb_rr_lock_arb;
   localparam int NP = 6;
   localparam int IW = 3;
   logic clk = 1'b0, rst = 1'b1, fire = 1'b0, grt_vld, timeout;
   logic [NP-1:0] req = '0, eop = '0, grt;
   logic [IW-1:0] grt_id;
   int n_cmp = 0, n_bad = 0;
   typedef struct {
      logic [NP-1:0] req;
      logic [NP-1:0] eop;
      logic          fire;
      logic [NP-1:0] g;
      logic [IW-1:0] id;
   } vec_t;
   vec_t v [24];

   always #5 clk = ~clk;

   rr_lock_arb #(.NPORT(NP), .IDW(IW), .MAX_HOLD(4)) dut (
      .clk(clk), .rst(rst), .req(req), .eop(eop), .fire(fire),
      .grt(grt), .grt_vld(grt_vld), .grt_id(grt_id), .timeout(timeout)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [NP-1:0] g, input logic [IW-1:0] id, input logic to);
      logic [NP+IW+1:0] a, e;
      a = {grt, grt_vld, grt_id, timeout};
      e = {g, |g, id, to};
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got grt=%b vld=%b id=%0d to=%b, want grt=%b vld=%b id=%0d to=%b",
                  nm, grt, grt_vld, grt_id, timeout, g, |g, id, to);
      end
   endtask

   task automatic do_reset();
      req = '0; eop = '0; fire = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      v[0]  = '{6'b000001, 6'b000000, 1'b0, 6'b000001, 3'd0};
      v[1]  = '{6'b111111, 6'b111111, 1'b1, 6'b000010, 3'd1};
      v[2]  = '{6'b111111, 6'b111111, 1'b1, 6'b000100, 3'd2};
      v[3]  = '{6'b111111, 6'b111111, 1'b1, 6'b001000, 3'd3};
      v[4]  = '{6'b111111, 6'b111111, 1'b1, 6'b010000, 3'd4};
      v[5]  = '{6'b111111, 6'b111111, 1'b1, 6'b100000, 3'd5};
      v[6]  = '{6'b111111, 6'b111111, 1'b1, 6'b000001, 3'd0};
      v[7]  = '{6'b111111, 6'b111111, 1'b1, 6'b000010, 3'd1};
      v[8]  = '{6'b111111, 6'b111111, 1'b1, 6'b000100, 3'd2};
      v[9]  = '{6'b111111, 6'b000000, 1'b1, 6'b000100, 3'd2};
      v[10] = '{6'b111111, 6'b000000, 1'b1, 6'b000100, 3'd2};
      v[11] = '{6'b111111, 6'b000000, 1'b1, 6'b000100, 3'd2};
      v[12] = '{6'b111111, 6'b000000, 1'b1, 6'b000100, 3'd2};
      v[13] = '{6'b111111, 6'b000000, 1'b1, 6'b000100, 3'd2};
      v[14] = '{6'b111111, 6'b000100, 1'b1, 6'b001000, 3'd3};
      v[15] = '{6'b111111, 6'b110111, 1'b1, 6'b001000, 3'd3};
      v[16] = '{6'b111111, 6'b001000, 1'b0, 6'b001000, 3'd3};
      v[17] = '{6'b000000, 6'b001000, 1'b1, 6'b000000, 3'd0};
      v[18] = '{6'b000000, 6'b111111, 1'b1, 6'b000000, 3'd0};
      v[19] = '{6'b100001, 6'b000000, 1'b0, 6'b100000, 3'd5};
      v[20] = '{6'b100000, 6'b111111, 1'b1, 6'b100000, 3'd5};
      v[21] = '{6'b100000, 6'b111111, 1'b1, 6'b100000, 3'd5};
      v[22] = '{6'b000000, 6'b000000, 1'b0, 6'b100000, 3'd5};
      v[23] = '{6'b000001, 6'b100000, 1'b1, 6'b000001, 3'd0};
      tick();
      tick();
      chk("reset", 6'b0, 3'd0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 24; i++) begin
         req = v[i].req; eop = v[i].eop; fire = v[i].fire;
         tick();
         chk($sformatf("vec%0d", i), v[i].g, v[i].id, 1'b0);
      end
      fire = 1'b0; eop = '0;
      rst = 1'b1;
      #2;
      chk("rst_async", 6'b0, 3'd0, 1'b0);
      req = 6'b110000;
      #1 rst = 1'b0;
      tick();
      chk("after_rst_scan", 6'b010000, 3'd4, 1'b0);
      do_reset();
      req = 6'b000010;
      tick();
      chk("own1", 6'b000010, 3'd1, 1'b0);
      req = 6'b000110;
`ifdef RR_LOCK_ARB_HOLD_TIMEOUT_EN
      repeat (3) tick();
      chk("hold_before_to", 6'b000010, 3'd1, 1'b0);
      tick();
      chk("to_pulse", 6'b000100, 3'd2, 1'b1);
      tick();
      chk("to_clear", 6'b000100, 3'd2, 1'b0);
      do_reset();
      req = 6'b000010;
      tick();
      chk("own1_b", 6'b000010, 3'd1, 1'b0);
      req = 6'b000110;
      repeat (3) tick();
      fire = 1'b1; eop = 6'b000010;
      tick();
      chk("eop_beats_to", 6'b000100, 3'd2, 1'b0);
`else
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("hold_forever%0d", i), 6'b000010, 3'd1, 1'b0);
      end
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
